// File: rtl/tlul_pkg.sv
// Shared TL-UL constants for the passive protocol checker: opcodes,
// violation bit positions and the A-to-D opcode pairing rule.
package tlul_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int NUM_ERR = 8;

  typedef enum logic [2:0] {
    ERR_A_UNSTABLE       = 3'd0,
    ERR_D_UNSTABLE       = 3'd1,
    ERR_A_BAD_OPCODE     = 3'd2,
    ERR_A_SRC_BUSY       = 3'd3,
    ERR_D_UNEXPECTED     = 3'd4,
    ERR_D_OPCODE_MISMATCH = 3'd5,
    ERR_D_SIZE_MISMATCH  = 3'd6,
    ERR_A_BAD_SIZE       = 3'd7
  } err_bit_e;

  function automatic logic is_legal_a_opcode(input logic [2:0] op);
    return (op == OP_PUT_FULL) || (op == OP_PUT_PARTIAL) || (op == OP_GET);
  endfunction

  function automatic logic [2:0] expected_d_opcode(input logic is_get);
    return is_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
  endfunction

endpackage

// File: rtl/tlul_src_table.sv
// Per-source outstanding request table. A retire and an allocate to the same
// source in one cycle leave the entry allocated (retire is applied first).
module tlul_src_table
  import tlul_pkg::*;
#(
  parameter int SRC_WIDTH  = 3,
  parameter int SIZE_WIDTH = 8,
  parameter int LAT_WIDTH  = 12,
  localparam int NUM_SRC   = 2**SRC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en,
  input  logic [SRC_WIDTH-1:0]  alloc_src,
  input  logic                  alloc_is_get,
  input  logic [SIZE_WIDTH-1:0] alloc_size,
  input  logic [LAT_WIDTH-1:0]  alloc_stamp,
  input  logic                  retire_en,
  input  logic [SRC_WIDTH-1:0]  retire_src,
  input  logic [SRC_WIDTH-1:0]  rd_src,
  output logic                  rd_is_get,
  output logic [SIZE_WIDTH-1:0] rd_size,
  output logic [LAT_WIDTH-1:0]  rd_stamp,
  output logic [NUM_SRC-1:0]    valid_vec,
  output logic [SRC_WIDTH:0]    count
);

  logic [NUM_SRC-1:0]    valid_q;
  logic [NUM_SRC-1:0]    is_get_q;
  logic [SIZE_WIDTH-1:0] size_q  [NUM_SRC];
  logic [LAT_WIDTH-1:0]  stamp_q [NUM_SRC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      is_get_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        size_q[i]  <= '0;
        stamp_q[i] <= '0;
      end
    end else begin
      if (retire_en) begin
        valid_q[retire_src] <= 1'b0;
      end
      if (alloc_en) begin
        valid_q[alloc_src]  <= 1'b1;
        is_get_q[alloc_src] <= alloc_is_get;
        size_q[alloc_src]   <= alloc_size;
        stamp_q[alloc_src]  <= alloc_stamp;
      end
    end
  end

  assign rd_is_get = is_get_q[rd_src];
  assign rd_size   = size_q[rd_src];
  assign rd_stamp  = stamp_q[rd_src];
  assign valid_vec = valid_q;

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      count = count + (SRC_WIDTH+1)'(valid_q[i]);
    end
  end

endmodule

// File: rtl/tlul_protocol_checker.sv
// Passive TL-UL A/D channel checker: stability, opcode/size legality and
// request/response pairing, with sticky flags, saturating counters and max latency.
module tlul_protocol_checker
  import tlul_pkg::*;
#(
  parameter int TL_ADDR_WIDTH   = 64,
  parameter int TL_DATA_WIDTH   = 64,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH/8,
  parameter int TL_SOURCE_WIDTH = 3,
  parameter int TL_SINK_WIDTH   = 3,
  parameter int TL_OPCODE_WIDTH = 3,
  parameter int TL_PARAM_WIDTH  = 3,
  parameter int TL_SIZE_WIDTH   = 8,
  parameter int CNT_WIDTH       = 16,
  parameter int LAT_WIDTH       = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stat_clr,
  input  logic                       a_valid,
  input  logic                       a_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  a_param,
  input  logic [TL_ADDR_WIDTH-1:0]   a_address,
  input  logic [TL_SIZE_WIDTH-1:0]   a_size,
  input  logic [TL_STRB_WIDTH-1:0]   a_mask,
  input  logic [TL_DATA_WIDTH-1:0]   a_data,
  input  logic [TL_SOURCE_WIDTH-1:0] a_source,
  input  logic                       d_valid,
  input  logic                       d_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  d_param,
  input  logic [TL_SIZE_WIDTH-1:0]   d_size,
  input  logic [TL_SINK_WIDTH-1:0]   d_sink,
  input  logic [TL_SOURCE_WIDTH-1:0] d_source,
  input  logic [TL_DATA_WIDTH-1:0]   d_data,
  input  logic                       d_error,
  output logic [7:0]                 err_flags,
  output logic                       err_valid,
  output logic [2:0]                 err_code,
  output logic [TL_SOURCE_WIDTH:0]   outstanding,
  output logic [CNT_WIDTH-1:0]       wr_cnt,
  output logic [CNT_WIDTH-1:0]       rd_cnt,
  output logic [CNT_WIDTH-1:0]       derr_cnt,
  output logic [LAT_WIDTH-1:0]       max_latency
);

  localparam int NUM_SRC  = 2**TL_SOURCE_WIDTH;
  localparam int MAX_SIZE = $clog2(TL_STRB_WIDTH);
  localparam logic [TL_OPCODE_WIDTH-1:0] OPC_GET = TL_OPCODE_WIDTH'(OP_GET);

  logic a_fire;
  logic d_fire;
  assign a_fire = a_valid & a_ready;
  assign d_fire = d_valid & d_ready;

  // Previous-cycle copies of both channels; compared only when the beat stalled.
  logic                       a_pend_q;
  logic [TL_OPCODE_WIDTH-1:0] a_opcode_q;
  logic [TL_PARAM_WIDTH-1:0]  a_param_q;
  logic [TL_ADDR_WIDTH-1:0]   a_address_q;
  logic [TL_SIZE_WIDTH-1:0]   a_size_q;
  logic [TL_STRB_WIDTH-1:0]   a_mask_q;
  logic [TL_DATA_WIDTH-1:0]   a_data_q;
  logic [TL_SOURCE_WIDTH-1:0] a_source_q;
  logic                       d_pend_q;
  logic [TL_OPCODE_WIDTH-1:0] d_opcode_q;
  logic [TL_PARAM_WIDTH-1:0]  d_param_q;
  logic [TL_SIZE_WIDTH-1:0]   d_size_q;
  logic [TL_SINK_WIDTH-1:0]   d_sink_q;
  logic [TL_SOURCE_WIDTH-1:0] d_source_q;
  logic [TL_DATA_WIDTH-1:0]   d_data_q;
  logic                       d_error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_pend_q    <= 1'b0;
      a_opcode_q  <= '0;
      a_param_q   <= '0;
      a_address_q <= '0;
      a_size_q    <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      a_source_q  <= '0;
      d_pend_q    <= 1'b0;
      d_opcode_q  <= '0;
      d_param_q   <= '0;
      d_size_q    <= '0;
      d_sink_q    <= '0;
      d_source_q  <= '0;
      d_data_q    <= '0;
      d_error_q   <= 1'b0;
    end else begin
      a_pend_q    <= a_valid & ~a_ready;
      a_opcode_q  <= a_opcode;
      a_param_q   <= a_param;
      a_address_q <= a_address;
      a_size_q    <= a_size;
      a_mask_q    <= a_mask;
      a_data_q    <= a_data;
      a_source_q  <= a_source;
      d_pend_q    <= d_valid & ~d_ready;
      d_opcode_q  <= d_opcode;
      d_param_q   <= d_param;
      d_size_q    <= d_size;
      d_sink_q    <= d_sink;
      d_source_q  <= d_source;
      d_data_q    <= d_data;
      d_error_q   <= d_error;
    end
  end

  logic a_changed;
  logic d_changed;
  assign a_changed = (a_opcode != a_opcode_q) || (a_param != a_param_q) ||
                     (a_address != a_address_q) || (a_size != a_size_q) ||
                     (a_mask != a_mask_q) || (a_data != a_data_q) ||
                     (a_source != a_source_q);
  assign d_changed = (d_opcode != d_opcode_q) || (d_param != d_param_q) ||
                     (d_size != d_size_q) || (d_sink != d_sink_q) ||
                     (d_source != d_source_q) || (d_data != d_data_q) ||
                     (d_error != d_error_q);

  logic [LAT_WIDTH-1:0]       timer_q;
  logic [NUM_SRC-1:0]         valid_vec;
  logic                       rd_is_get;
  logic [TL_SIZE_WIDTH-1:0]   rd_size;
  logic [LAT_WIDTH-1:0]       rd_stamp;
  logic [TL_SOURCE_WIDTH:0]   table_count;
  logic                       a_legal;
  logic                       alloc_en;
  logic                       d_hit;

  assign a_legal  = is_legal_a_opcode(3'(a_opcode)) &&
                    (a_opcode == TL_OPCODE_WIDTH'(3'(a_opcode)));
  assign alloc_en = a_fire & a_legal;
  assign d_hit    = d_fire & valid_vec[d_source];

  tlul_src_table #(
    .SRC_WIDTH  (TL_SOURCE_WIDTH),
    .SIZE_WIDTH (TL_SIZE_WIDTH),
    .LAT_WIDTH  (LAT_WIDTH)
  ) u_src_table (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_en),
    .alloc_src    (a_source),
    .alloc_is_get (a_opcode == OPC_GET),
    .alloc_size   (a_size),
    .alloc_stamp  (timer_q),
    .retire_en    (d_hit),
    .retire_src   (d_source),
    .rd_src       (d_source),
    .rd_is_get    (rd_is_get),
    .rd_size      (rd_size),
    .rd_stamp     (rd_stamp),
    .valid_vec    (valid_vec),
    .count        (table_count)
  );

  assign outstanding = table_count;

  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    for (int i = 0; i < TL_ADDR_WIDTH; i++) begin
      if ((i < int'(a_size)) && a_address[i]) misaligned = 1'b1;
    end
  end

  // A retire on the same source this cycle frees the entry before reallocation.
  logic [NUM_ERR-1:0] viol;
  always_comb begin
    viol = '0;
    viol[ERR_A_UNSTABLE]        = a_pend_q & (~a_valid | a_changed);
    viol[ERR_D_UNSTABLE]        = d_pend_q & (~d_valid | d_changed);
    viol[ERR_A_BAD_OPCODE]      = a_fire & ~a_legal;
    viol[ERR_A_SRC_BUSY]        = a_fire & valid_vec[a_source] &
                                  ~(d_hit && (d_source == a_source));
    viol[ERR_D_UNEXPECTED]      = d_fire & ~valid_vec[d_source];
    viol[ERR_D_OPCODE_MISMATCH] = d_hit &
                                  (d_opcode != TL_OPCODE_WIDTH'(expected_d_opcode(rd_is_get)));
    viol[ERR_D_SIZE_MISMATCH]   = d_hit & (d_size != rd_size);
    viol[ERR_A_BAD_SIZE]        = a_fire &
                                  ((a_size > TL_SIZE_WIDTH'(MAX_SIZE)) | misaligned);
  end

  logic [2:0] viol_code;
  always_comb begin
    viol_code = '0;
    for (int i = NUM_ERR-1; i >= 0; i--) begin
      if (viol[i]) viol_code = 3'(i);
    end
  end

  logic [LAT_WIDTH-1:0] latency;
  assign latency = timer_q - rd_stamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + LAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      err_valid <= |viol;
      err_code  <= viol_code;
    end
  end

  // Statistics; a clear request overrides whatever would update this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flags   <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      derr_cnt    <= '0;
      max_latency <= '0;
    end else if (stat_clr) begin
      err_flags   <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      derr_cnt    <= '0;
      max_latency <= '0;
    end else begin
      err_flags <= err_flags | viol;
      if (d_hit) begin
        if (!rd_is_get && (wr_cnt != '1)) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
        if (rd_is_get && (rd_cnt != '1))  rd_cnt <= rd_cnt + CNT_WIDTH'(1);
        if (d_error && (derr_cnt != '1))  derr_cnt <= derr_cnt + CNT_WIDTH'(1);
        if (latency > max_latency)        max_latency <= latency;
      end
    end
  end

endmodule

// File: doc/tlul_protocol_checker.md
Name: tlul_protocol_checker

Overview:
Synthesizable, parametrised TL-UL passive protocol checker and statistics monitor, instantiated alongside the TL-UL to xSPI bridge on the A/D channel pair. Observes handshakes only and never drives the bus. Tracks outstanding requests per source ID, checks channel stability and request/response pairing, and reports sticky error flags, per-event error pulses, saturating traffic counters and worst-case request-to-response latency.

Parameters:
TL_ADDR_WIDTH, 64, address width
TL_DATA_WIDTH, 64, data width
TL_STRB_WIDTH, TL_DATA_WIDTH/8, mask width
TL_SOURCE_WIDTH, 3, source ID width; table depth NUM_SRC = 2**TL_SOURCE_WIDTH
TL_SINK_WIDTH, 3, sink width
TL_OPCODE_WIDTH, 3, opcode width
TL_PARAM_WIDTH, 3, param width
TL_SIZE_WIDTH, 8, size field width (log2 bytes)
CNT_WIDTH, 16, traffic/error counter width (saturating)
LAT_WIDTH, 12, latency timestamp width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stat_clr  in  1  synchronous clear of counters, flags and max_latency
a_valid, a_ready  in  1 each  A handshake
a_opcode  in  TL_OPCODE_WIDTH
a_param  in  TL_PARAM_WIDTH
a_address  in  TL_ADDR_WIDTH
a_size  in  TL_SIZE_WIDTH
a_mask  in  TL_STRB_WIDTH
a_data  in  TL_DATA_WIDTH
a_source  in  TL_SOURCE_WIDTH
d_valid, d_ready  in  1 each  D handshake
d_opcode  in  TL_OPCODE_WIDTH
d_param  in  TL_PARAM_WIDTH
d_size  in  TL_SIZE_WIDTH
d_sink  in  TL_SINK_WIDTH
d_source  in  TL_SOURCE_WIDTH
d_data  in  TL_DATA_WIDTH
d_error  in  1
err_flags  out  8  sticky violation bits
err_valid  out  1  one-cycle pulse per cycle with any new violation
err_code  out  3  index of lowest violation bit in that cycle
outstanding  out  TL_SOURCE_WIDTH+1  current outstanding request count
wr_cnt, rd_cnt, derr_cnt  out  CNT_WIDTH each  completed writes, reads, d_error responses
max_latency  out  LAT_WIDTH  worst A-fire to D-fire latency in cycles

Behaviour:
- a_fire = a_valid & a_ready; d_fire = d_valid & d_ready.
- Reset: all outputs 0, table entries invalid, cycle timer 0, held-channel snapshots cleared.
- Legal A opcodes: 0 PutFullData, 1 PutPartialData, 4 Get. Expected D opcode: 0 AccessAck for Put*, 1 AccessAckData for Get.
- Table: per source {valid, is_get, size, timestamp}. Written on a_fire with a legal opcode. Cleared on d_fire to a valid entry.
- Same-cycle d_fire and a_fire on the same source: retire first, then allocate. No A_SRC_BUSY is raised.
- Violation bits:
  - 0 A_UNSTABLE: previous cycle a_valid & !a_ready, and now a_valid=0 or any A field differs from the snapshot.
  - 1 D_UNSTABLE: same rule on the D channel.
  - 2 A_BAD_OPCODE: a_fire with an illegal opcode. No allocation.
  - 3 A_SRC_BUSY: a_fire to a valid entry not retired this cycle. Entry is overwritten.
  - 4 D_UNEXPECTED: d_fire to an invalid entry. No counters change.
  - 5 D_OPCODE_MISMATCH.
  - 6 D_SIZE_MISMATCH: d_size differs from the stored size.
  - 7 A_BAD_SIZE: a_size > log2(TL_STRB_WIDTH), or a_address low a_size bits nonzero.
- Violations are registered. err_valid, err_code and the err_flags OR update one cycle after the offending cycle.
- Counters update one cycle after a valid-entry d_fire: wr_cnt if !is_get, rd_cnt if is_get, derr_cnt if d_error. All saturate at all-ones.
- Latency: a free-running LAT_WIDTH timer. Latency = (timer - stamp) mod 2**LAT_WIDTH; results beyond 2**LAT_WIDTH-1 alias. max_latency takes the larger value.
- outstanding = popcount of valid entries, updated the cycle after a fire.
- stat_clr clears counters, flags and max_latency, and wins over same-cycle updates. It does not touch the table or outstanding.
- Async reset mid-transaction clears the table. Later responses to those sources raise D_UNEXPECTED.

Decomposition:
- tlul_pkg: A/D opcode constants, violation bit indices, expected-D-opcode function.
- Sub-module tlul_src_table: the per-source valid/is_get/size/stamp array with alloc/retire ports and popcount.

Test Plan:
- Put src 2 addr 0x10 size 3, D AccessAck src 2 five cycles later -> wr_cnt=1, max_latency=5, outstanding back to 0, err_flags=0.
- Get src 1 with a_ready low 3 cycles and a_address changed in cycle 2 -> err_flags[0]=1, err_valid pulse, err_code=0.
- Two Gets src 4 with no response between -> err_flags[3]=1, outstanding=1.
- D AccessAck src 6 with nothing outstanding -> err_flags[4]=1, counters unchanged.
- Get src 0 answered with AccessAck and d_size differing -> err_flags[5]=1 and err_flags[6]=1, err_code=5.
- Get size 2 at addr 0x6 -> err_flags[7]=1. Then stat_clr -> flags and counters 0, outstanding unchanged.
